// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional checksum stage is enabled with LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    function automatic logic is_rx(state_t s);
        return (s == S_LEN0) || (s == S_LEN1) ||
               (s == S_DATA) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte counter and little-endian shift register for one memory word.
// word is the value completed by the byte currently being pushed.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [7:0]    in_byte,
    output logic [WD-1:0] word,
    output logic          full
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] r_cnt;
    logic [WD-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else begin
            if (clr)
                r_cnt <= '0;
            else if (push)
                r_cnt <= r_cnt + CW'(1);
            if (push)
                r_sr <= {in_byte, r_sr[WD-1:8]};
        end
    end

    // Three bytes buffered: the next push completes the word.
    assign full = (r_cnt == CW'(BYTES_PER_WORD - 1));
    assign word = {in_byte, r_sr[WD-1:8]};

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream loader into instruction memory; holds core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WD = 32,
    parameter int WM = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [WM-1:0] mem_addr,
    output logic [WD-1:0] mem_wdata,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    localparam logic [LEN_W:0] CAP = (LEN_W + 1)'(1) << WM;

    state_t           r_state;
    state_t           w_nxt;
    logic [LEN_W-1:0] r_len;
    logic [WM:0]      r_idx;
    logic [WM-1:0]    r_addr;
    logic [WD-1:0]    r_wdata;
    logic             r_in_ready;
    logic             r_mem_we;
    logic             r_cpu_rst;
    logic             r_done;
    logic             r_err;

    logic             w_xfer;
    logic             w_push;
    logic             w_clr;
    logic             w_full;
    logic [WD-1:0]    w_word;
    logic [LEN_W-1:0] w_n;
    logic             w_zero;
    logic             w_over;
    logic             w_last;
    logic             w_chk_ok;

    assign w_xfer = in_valid && r_in_ready;
    assign w_push = w_xfer && (r_state == S_DATA);
    assign w_clr  = (r_state == S_LEN1) || (r_state == S_WRITE);
    assign w_n    = {in_data, r_len[7:0]};
    assign w_zero = (w_n == '0);
    assign w_over = {1'b0, w_n} > CAP;
    assign w_last = (LEN_W'(r_idx) + LEN_W'(1)) == r_len;

    word_assembler #(.WD(WD)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .push    (w_push),
        .in_byte (in_data),
        .word    (w_word),
        .full    (w_full)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    // Running XOR of data bytes only; restarts with every session.
    always_ff @(posedge clk) begin
        if (rst)
            r_xor <= '0;
        else if (r_state == S_LEN0)
            r_xor <= '0;
        else if (w_push)
            r_xor <= r_xor ^ in_data;
    end

    assign w_chk_ok = (in_data == r_xor);
`else
    assign w_chk_ok = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR:
                if (start) w_nxt = S_LEN0;
            S_LEN0:
                if (w_xfer) w_nxt = S_LEN1;
            S_LEN1:
                if (w_xfer) begin
                    if (w_zero)      w_nxt = S_FIN;
                    else if (w_over) w_nxt = S_ERR;
                    else             w_nxt = S_DATA;
                end
            S_DATA:
                if (w_xfer && w_full) w_nxt = S_WRITE;
            S_WRITE:
                w_nxt = w_last ? S_FIN : S_DATA;
            S_CHK:
                if (w_xfer) w_nxt = w_chk_ok ? S_DONE : S_ERR;
            default:
                w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_in_ready <= is_rx(w_nxt);
            r_mem_we   <= (w_nxt == S_WRITE);
            r_cpu_rst  <= (w_nxt != S_DONE);
            r_done     <= (w_nxt == S_DONE);
            r_err      <= (w_nxt == S_ERR);
            if (r_state == S_LEN0 && w_xfer)
                r_len[7:0] <= in_data;
            if (r_state == S_LEN1 && w_xfer) begin
                r_len[LEN_W-1:8] <= in_data;
                r_idx            <= '0;
            end
            if (w_push && w_full) begin
                r_addr  <= r_idx[WM-1:0];
                r_wdata <= w_word;
            end
            if (r_state == S_WRITE && !w_last)
                r_idx <= r_idx + (WM + 1)'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed sequences plus a randomized table.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int WM  = 10;
    localparam int CAP = 1 << WM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [WM-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(.WD(32), .WM(WM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        int n;
        int gap;
        bit bad_chk;
        bit ok;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [7:0]  stream[$];
    vec_t        tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (done && done_cyc < 0)
            done_cyc <= cyc;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(gap, 0)) tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL ready_wait: in_ready stuck at 0 for byte %0h", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int gap);
        int k;
        wa.delete();
        wd.delete();
        wc.delete();
        done_cyc = -1;
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], gap);
        in_valid = 1'b0;
        k = 0;
        while (!(done || err) && k < 20) begin
            @(negedge clk);
            k++;
        end
        tick();
    endtask

    task automatic build(input int n, input bit bad_chk);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        if (n <= CAP) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                stream.push_back(b);
                x ^= b;
            end
`ifdef LOADER_CHECKSUM_EN
            stream.push_back(x ^ {7'b0, bad_chk});
`endif
        end
    endtask

    task automatic verify(input string nm, input int n, input bit ok);
        int ew;
        int bad;
        logic [31:0] e;
        ew  = (n <= CAP) ? n : 0;
        bad = 0;
        check({nm, "_nwr"}, wa.size(), ew);
        if (wa.size() == ew) begin
            for (int i = 0; i < ew; i++) begin
                e = 32'(stream[2 + 4 * i])
                  + 32'(stream[3 + 4 * i]) * 32'd256
                  + 32'(stream[4 + 4 * i]) * 32'd65536
                  + 32'(stream[5 + 4 * i]) * 32'd16777216;
                if (wa[i] != i || wd[i] != e) bad++;
            end
        end
        check({nm, "_words"}, bad, 0);
        check({nm, "_done"}, done, ok);
        check({nm, "_err"}, err, !ok);
        check({nm, "_cpu_rst"}, cpu_rst, !ok);
    endtask

    task automatic load_fixed;
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                   8'h93, 8'h00, 8'hA0, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h13 ^ 8'h50 ^ 8'h93 ^ 8'hA0);
`endif
    endtask

    initial begin
        tbl.push_back('{n: 1,       gap: 0, bad_chk: 0, ok: 1});
        tbl.push_back('{n: 3,       gap: 3, bad_chk: 0, ok: 1});
        tbl.push_back('{n: 0,       gap: 1, bad_chk: 0, ok: 1});
        tbl.push_back('{n: CAP + 1, gap: 0, bad_chk: 0, ok: 0});
        tbl.push_back('{n: 5,       gap: 2, bad_chk: 0, ok: 1});
        tbl.push_back('{n: CAP,     gap: 1, bad_chk: 0, ok: 1});
        tbl.push_back('{n: 300,     gap: 0, bad_chk: 0, ok: 0});
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back('{n: 4,       gap: 1, bad_chk: 1, ok: 0});
`endif
        // 300 > 255 exercises the high length byte; only over-capacity fails.
        tbl[6].ok = (300 <= CAP);

        // Reset with in_valid high
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) tick();
        @(negedge clk);
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1'b0);
        pulse_start();
        check("start_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Known two-word image, back-to-back bytes
        load_fixed();
        run_stream(0);
        check("t2_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t2_addr0", wa[0], 0);
            check("t2_data0", wd[0], 32'h00500013);
            check("t2_addr1", wa[1], 1);
            check("t2_data1", wd[1], 32'h00A00093);
`ifndef LOADER_CHECKSUM_EN
            check("t2_done_lat", done_cyc, wc[1] + 1);
`endif
        end
        check("t2_done", done, 1'b1);
        check("t2_cpu_rst", cpu_rst, 1'b0);

        // Same image with random valid gaps
        load_fixed();
        run_stream(3);
        verify("t3", 2, 1'b1);

        // Oversized image, then an empty one
        build(CAP + 1, 1'b0);
        run_stream(0);
        verify("t4_over", CAP + 1, 1'b0);
        build(0, 1'b0);
        run_stream(0);
        verify("t4_empty", 0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        load_fixed();
        stream[10] = stream[10] ^ 8'h01;
        run_stream(1);
        verify("t5_badchk", 2, 1'b0);
`endif

        // Randomized table
        foreach (tbl[i]) begin
            build(tbl[i].n, tbl[i].bad_chk);
            run_stream(tbl[i].gap);
            verify($sformatf("tbl%0d", i), tbl[i].n, tbl[i].ok);
        end

        // Reset mid-word, then restart from DONE
        load_fixed();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cpu_rst", cpu_rst, 1'b1);
        check("t6_in_ready", in_ready, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_addr", mem_addr, '0);
        check("t6_wdata", mem_wdata, '0);
        tick();
        load_fixed();
        run_stream(0);
        verify("t6_reload", 2, 1'b1);
        pulse_start();
        check("t6_restart_cpu_rst", cpu_rst, 1'b1);
        check("t6_restart_done", done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
